tab_hash_sequencer: RTL and testbench

- Sequences one tabulation-hash computation over a shared, asynchronously read lookup table.
- Arbitrates round-robin between two key requesters.
- Splits each accepted key into byte chunks and issues one table lookup per cycle, using chunk index as sub-table select.
- XOR-accumulates the lookup results and returns the hash with the requester ID over a valid/ready response port. Sits between hash clients and the static table memory.

---
 rtl/tab_hash_sequencer_pkg.sv | 17 +
 rtl/tab_hash_sequencer_if.sv | 33 +++
 rtl/tab_hash_sequencer_rr_arbiter2.sv | 29 ++
 rtl/tab_hash_sequencer.sv | 132 +++++++++++++
 tb/tb_tab_hash_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/tab_hash_sequencer_pkg.sv
// Shared types and sizing helpers for the tabulation-hash sequencer.
package tab_hash_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int CHUNK_BITS_DFLT = 8;

  // Table address is {sub-table select, chunk value}.
  function automatic int addr_width(input int key_bytes, input int chunk_bits);
    return $clog2(key_bytes) + chunk_bits;
  endfunction

endpackage

// File: rtl/tab_hash_sequencer_if.sv
// Request, table-lookup and response bundle of the tabulation-hash sequencer.
interface tab_hash_sequencer_if
  import tab_hash_pkg::*;
#(
  parameter int KEY_BYTES  = 4,
  parameter int DBITS      = 32,
  parameter int CHUNK_BITS = CHUNK_BITS_DFLT
);

  localparam int AW = addr_width(KEY_BYTES, CHUNK_BITS);

  logic [1:0]                       req_valid;
  logic [1:0]                       req_ready;
  logic [2*KEY_BYTES*CHUNK_BITS-1:0] req_key;
  logic                             tbl_rd_en;
  logic [AW-1:0]                    tbl_addr;
  logic [DBITS-1:0]                 tbl_data;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [DBITS-1:0]                 rsp_hash;
  logic                             rsp_id;

  modport master (
    input  req_valid, req_key, tbl_data, rsp_ready,
    output req_ready, tbl_rd_en, tbl_addr, rsp_valid, rsp_hash, rsp_id
  );

  modport slave (
    output req_valid, req_key, tbl_data, rsp_ready,
    input  req_ready, tbl_rd_en, tbl_addr, rsp_valid, rsp_hash, rsp_id
  );

endinterface

// File: rtl/tab_hash_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter, one-hot grant, zero latency; the pointer only
// moves on an accepted grant so a stalled winner keeps its turn.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  // 0: requester 0 has priority, 1: requester 1 has priority
  logic r_prio;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_accept) begin
      r_prio <= o_grant[0];
    end
  end

endmodule

// File: rtl/tab_hash_sequencer.sv
// Tabulation hash over KEY_BYTES chunk lookups; response KEY_BYTES edges after
// accept, held until rsp_ready; no new key is accepted until the response drains.
module tab_hash_sequencer
  import tab_hash_pkg::*;
#(
  parameter int KEY_BYTES  = 4,
  parameter int DBITS      = 32,
  parameter int CHUNK_BITS = CHUNK_BITS_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tab_hash_sequencer_if.master bus,
  output logic                 busy,
  output logic [15:0]          hash_count
);

  localparam int IW = $clog2(KEY_BYTES);
  localparam int KW = KEY_BYTES * CHUNK_BITS;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_gid;
  logic                  w_last;
  logic [CHUNK_BITS-1:0] w_chunk;
  logic [DBITS-1:0]      w_acc_nxt;

  logic [KW-1:0]         r_key;
  logic                  r_id;
  logic [IW-1:0]         r_idx;
  logic [DBITS-1:0]      r_acc;
  logic [DBITS-1:0]      r_hash;
  logic                  r_rsp_vld;
  logic [15:0]           r_count;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (bus.req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // rst_n gates the accept so req_ready drops the instant reset asserts.
  assign w_accept  = rst_n && (r_state == IDLE) && (|(w_grant & bus.req_valid));
  assign w_gid     = w_grant[1];
  assign w_last    = (r_idx == IW'(KEY_BYTES - 1));
  assign w_chunk   = r_key[r_idx*CHUNK_BITS +: CHUNK_BITS];
  assign w_acc_nxt = r_acc ^ bus.tbl_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.tbl_rd_en = 1'b0;
    bus.tbl_addr  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          bus.req_ready = w_grant;
          w_next        = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.tbl_rd_en = 1'b1;
        bus.tbl_addr  = {r_idx, w_chunk};
        if (w_last) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key     <= '0;
      r_id      <= 1'b0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_hash    <= '0;
      r_rsp_vld <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_key <= bus.req_key[w_gid*KW +: KW];
            r_id  <= w_gid;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        LOOKUP: begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_hash    <= w_acc_nxt;
            r_rsp_vld <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_vld <= 1'b0;
            r_count   <= r_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_hash  = r_hash;
  assign bus.rsp_id    = r_id;
  assign busy          = (r_state != IDLE);
  assign hash_count    = r_count;

endmodule

// File: tb/tb_tab_hash_sequencer.sv
// Directed bench for tab_hash_sequencer; table entry T[a] = a * 0x00010001.
module tb_tab_hash_sequencer;

  localparam int KB = 4;
  localparam int DB = 32;
  localparam int CB = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] hash_count;
  int          n_pass   = 0;
  int          n_checks = 0;

  tab_hash_sequencer_if #(.KEY_BYTES(KB), .DBITS(DB), .CHUNK_BITS(CB)) bus ();

  tab_hash_sequencer #(.KEY_BYTES(KB), .DBITS(DB), .CHUNK_BITS(CB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .hash_count (hash_count)
  );

  always #5 clk = ~clk;

  assign bus.tbl_data = 32'(bus.tbl_addr) * 32'h0001_0001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (bus.rsp_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_seen"}, 32'(bus.rsp_valid), 32'h1);
  endtask

  // Expects rsp_ready=1: checks the response, then steps past its handshake.
  task automatic run_one(input string tag, input logic exp_id, input logic [31:0] exp_hash);
    wait_rsp(tag);
    check({tag, "_id"},   32'(bus.rsp_id), 32'(exp_id));
    check({tag, "_hash"}, bus.rsp_hash,    exp_hash);
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_key   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_hash",  bus.rsp_hash,       32'h0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    check("rst_count",     32'(hash_count),    32'h0);
    check("rst_busy",      32'(busy),          32'h0);
    check("rst_rd_en",     32'(bus.tbl_rd_en), 32'h0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 0: address sequence and latency
    bus.req_key[31:0] = 32'h0403_0201;
    bus.req_valid     = 2'b01;
    bus.rsp_ready     = 1'b1;
    #1;
    check("t1_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("t1_busy",  32'(busy),          32'h1);
    check("t1_rd_en", 32'(bus.tbl_rd_en), 32'h1);
    check("t1_addr0", 32'(bus.tbl_addr),  32'h001);
    @(negedge clk);
    check("t1_addr1", 32'(bus.tbl_addr),  32'h102);
    @(negedge clk);
    check("t1_addr2", 32'(bus.tbl_addr),  32'h203);
    @(negedge clk);
    check("t1_addr3",    32'(bus.tbl_addr),  32'h304);
    check("t1_vld_edge3", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    check("t1_vld_edge4", 32'(bus.rsp_valid), 32'h1);
    check("t1_hash",      bus.rsp_hash,       32'h0004_0004);
    check("t1_id",        32'(bus.rsp_id),    32'h0);
    check("t1_rd_en_off", 32'(bus.tbl_rd_en), 32'h0);
    check("t1_addr_off",  32'(bus.tbl_addr),  32'h0);
    @(negedge clk);
    check("t1_vld_drop", 32'(bus.rsp_valid), 32'h0);
    check("t1_count",    32'(hash_count),    32'h1);
    check("t1_idle",     32'(busy),          32'h0);

    // Zero key from requester 1
    bus.req_key[63:32] = 32'h0;
    bus.req_valid      = 2'b10;
    #1;
    check("t2_req_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    run_one("t2", 1'b1, 32'h0000_0000);
    check("t2_count", 32'(hash_count), 32'h2);

    // Both requesters held valid: grants alternate 0,1,0,1
    bus.req_key   = {32'h0000_00FF, 32'h1122_3344};
    bus.req_valid = 2'b11;
    run_one("t3a", 1'b0, 32'h0044_0044);
    run_one("t3b", 1'b1, 32'h00FF_00FF);
    run_one("t3c", 1'b0, 32'h0044_0044);
    run_one("t3d", 1'b1, 32'h00FF_00FF);
    bus.req_valid = 2'b00;
    check("t3_count", 32'(hash_count), 32'h6);

    // Backpressure for 10 cycles while both requesters wait
    bus.req_key[31:0] = 32'h0403_0201;
    bus.req_valid     = 2'b11;
    bus.rsp_ready     = 1'b0;
    wait_rsp("t4");
    check("t4_id", 32'(bus.rsp_id), 32'h0);
    for (int c = 0; c < 10; c++) begin
      check("t4_hold_vld",   32'(bus.rsp_valid), 32'h1);
      check("t4_hold_hash",  bus.rsp_hash,       32'h0004_0004);
      check("t4_hold_ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t4_vld_drop", 32'(bus.rsp_valid), 32'h0);
    check("t4_idle",     32'(busy),          32'h0);
    check("t4_count",    32'(hash_count),    32'h7);
    @(negedge clk);
    check("t4_single_hs", 32'(bus.rsp_valid), 32'h0);

    // Reset in the middle of LOOKUP
    bus.req_key   = {32'h0000_00FF, 32'h1122_3344};
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("t5_mid_busy", 32'(busy),         32'h1);
    check("t5_mid_addr", 32'(bus.tbl_addr), 32'h222);
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check("t5_rst_vld",   32'(bus.rsp_valid), 32'h0);
    check("t5_rst_busy",  32'(busy),          32'h0);
    check("t5_rst_rd_en", 32'(bus.tbl_rd_en), 32'h0);
    check("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    check("t5_rst_count", 32'(hash_count),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_first_grant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("t5_no_stale", 32'(bus.rsp_valid), 32'h0);
    run_one("t5", 1'b0, 32'h0044_0044);
    check("t5_count", 32'(hash_count), 32'h1);

    // hash_count wraps 0xFFFF -> 0x0000
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    #1;
    check("t6_preload", 32'(hash_count), 32'hFFFF);
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b00;
    run_one("t6", 1'b1, 32'h00FF_00FF);
    check("t6_wrap", 32'(hash_count), 32'h0);
    check("t6_idle", 32'(busy),       32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
